// File: rtl/aib_mac_dv_pkg.sv
// Shared definitions for the AIB MAC pattern generator and its future RX checker.
package aib_mac_dv_pkg;

  typedef enum logic [1:0] {
    GEN_IDLE,
    GEN_WAIT_LINK,
    GEN_SEND,
    GEN_DONE
  } gen_state_t;

  localparam int PRBS31_TAP_A = 30;
  localparam int PRBS31_TAP_B = 27;

  // One Fibonacci step of x^31+x^28+1: feedback bit enters at bit 0.
  function automatic logic [30:0] prbs31_next(input logic [30:0] s);
    return {s[29:0], s[PRBS31_TAP_A] ^ s[PRBS31_TAP_B]};
  endfunction

endpackage

// File: rtl/aib_prbs31_lfsr.sv
// PRBS31 state register with load and single-step advance; shared with the RX checker.
module aib_prbs31_lfsr
  import aib_mac_dv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [30:0] seed,
  input  logic        advance,
  output logic [30:0] state
);

  // Load wins over advance; an all-zero seed would lock the LFSR, so it becomes 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= 31'h1;
    end else if (load) begin
      state <= (seed == 31'h0) ? 31'h1 : seed;
    end else if (advance) begin
      state <= prbs31_next(state);
    end
  end

endmodule

// File: rtl/aib_mac_tx_pattern_gen.sv
// MAC-side counter/PRBS31 word source for one AIB channel, with optional FIFO-mode markers.
module aib_mac_tx_pattern_gen
  import aib_mac_dv_pkg::*;
#(
  parameter int DWIDTH  = 40,
  parameter int CNT_W   = 16,
  parameter int LINK_TO = 1023
) (
  input  logic                  wr_clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  mode_prbs,
  input  logic                  marker_en,
  input  logic [30:0]           seed,
  input  logic [CNT_W-1:0]      num_words,
  input  logic                  ns_mac_rdy,
  input  logic                  fs_mac_rdy,
  input  logic                  tx_transfer_en,
  output logic [DWIDTH*2-1:0]   data_in,
  output logic                  data_vld,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout,
  output logic [CNT_W-1:0]      word_cnt
);

  localparam int OW   = DWIDTH * 2;
  localparam int REPS = (OW + 30) / 31;
  localparam int TW   = (LINK_TO < 1) ? 1 : $clog2(LINK_TO + 1);
  localparam logic [TW-1:0]    LINK_TO_V = TW'(LINK_TO);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  gen_state_t        state, state_next;
  logic              link_ok_q;
  logic [TW-1:0]     timer;
  logic              cfg_prbs, cfg_marker;
  logic [CNT_W-1:0]  cfg_num;
  logic [30:0]       lfsr;
  logic [REPS*31-1:0] rep;
  logic [OW-1:0]     word;
  logic              load_cfg, emit, set_timeout;

  aib_prbs31_lfsr u_lfsr (
    .clk     (wr_clk),
    .rst     (rst),
    .load    (load_cfg),
    .seed    (seed),
    .advance (emit & cfg_prbs),
    .state   (lfsr)
  );

  assign busy = (state == GEN_WAIT_LINK) || (state == GEN_SEND);
  assign done = (state == GEN_DONE);

  // State register.
  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) state <= GEN_IDLE;
    else     state <= state_next;
  end

  // Next-state and control strobes; abort has priority, then start, then the rest.
  always_comb begin
    state_next  = state;
    load_cfg    = 1'b0;
    emit        = 1'b0;
    set_timeout = 1'b0;
    if (abort) begin
      state_next = GEN_IDLE;
    end else begin
      case (state)
        GEN_IDLE, GEN_DONE: begin
          if (start) begin
            state_next = GEN_WAIT_LINK;
            load_cfg   = 1'b1;
          end
        end
        GEN_WAIT_LINK: begin
          if (link_ok_q) begin
            state_next = GEN_SEND;
          end else if (timer == LINK_TO_V) begin
            state_next  = GEN_IDLE;
            set_timeout = 1'b1;
          end
        end
        GEN_SEND: begin
          if ((cfg_num != '0) && (word_cnt == cfg_num)) state_next = GEN_DONE;
          else if (link_ok_q)                           emit       = 1'b1;
        end
        default: state_next = GEN_IDLE;
      endcase
    end
  end

  // Payload: counter or replicated LFSR, with marker bits forced on top when enabled.
  always_comb begin
    rep  = {REPS{lfsr}};
    word = cfg_prbs ? rep[OW-1:0] : OW'(word_cnt);
    if (cfg_marker) begin
      word[OW-1]     = 1'b1;
      word[DWIDTH-1] = 1'b0;
    end
  end

  // Link qualifier, WAIT_LINK timer, run config and sticky timeout.
  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      link_ok_q  <= 1'b0;
      timer      <= '0;
      cfg_prbs   <= 1'b0;
      cfg_marker <= 1'b0;
      cfg_num    <= '0;
      timeout    <= 1'b0;
    end else begin
      link_ok_q <= ns_mac_rdy & fs_mac_rdy & tx_transfer_en;
      if ((state == GEN_WAIT_LINK) && (state_next == GEN_WAIT_LINK)) timer <= timer + TW'(1);
      else                                                         timer <= '0;
      if (load_cfg) begin
        cfg_prbs   <= mode_prbs;
        cfg_marker <= marker_en;
        cfg_num    <= num_words;
        timeout    <= 1'b0;
      end else if (set_timeout) begin
        timeout <= 1'b1;
      end
    end
  end

  // Registered word output and saturating word counter; data_in holds between words.
  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      data_in  <= '0;
      data_vld <= 1'b0;
      word_cnt <= '0;
    end else begin
      data_vld <= emit;
      if (emit) data_in <= word;
      if (load_cfg)                          word_cnt <= '0;
      else if (emit && (word_cnt != CNT_MAX)) word_cnt <= word_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_aib_mac_tx_pattern_gen.sv
// Directed bench for aib_mac_tx_pattern_gen with hand-computed expected words.
module tb_aib_mac_tx_pattern_gen;

  localparam int DWIDTH = 40;
  localparam int CNT_W  = 16;
  localparam int OW     = 80;

  logic              wr_clk = 1'b0;
  logic              rst;
  logic              start, abort, mode_prbs, marker_en;
  logic [30:0]       seed;
  logic [CNT_W-1:0]  num_words;
  logic              ns_mac_rdy, fs_mac_rdy, tx_transfer_en;
  logic [OW-1:0]     data_in;
  logic              data_vld, busy, done, timeout;
  logic [CNT_W-1:0]  word_cnt;

  int checks = 0;
  int errors = 0;

  aib_mac_tx_pattern_gen #(.DWIDTH(DWIDTH), .CNT_W(CNT_W), .LINK_TO(15)) dut (
    .wr_clk         (wr_clk),
    .rst            (rst),
    .start          (start),
    .abort          (abort),
    .mode_prbs      (mode_prbs),
    .marker_en      (marker_en),
    .seed           (seed),
    .num_words      (num_words),
    .ns_mac_rdy     (ns_mac_rdy),
    .fs_mac_rdy     (fs_mac_rdy),
    .tx_transfer_en (tx_transfer_en),
    .data_in        (data_in),
    .data_vld       (data_vld),
    .busy           (busy),
    .done           (done),
    .timeout        (timeout),
    .word_cnt       (word_cnt)
  );

  always #5 wr_clk = ~wr_clk;

  // Advance one clock and settle 1 time unit past the edge.
  task automatic tick();
    @(posedge wr_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Tick, then expect a valid word with the given payload and post-increment count.
  task automatic expect_word(input string tag, input logic [OW-1:0] exp, input int exp_cnt);
    tick();
    check({tag, " vld"}, OW'(data_vld), OW'(1));
    check({tag, " data"}, data_in, exp);
    check({tag, " cnt"}, OW'(word_cnt), OW'(exp_cnt));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Replicated-LFSR payload for an 80-bit word.
  function automatic logic [OW-1:0] prbs_word(input logic [30:0] v);
    logic [OW-1:0] x;
    x = OW'(v);
    return x | (x << 31) | (x << 62);
  endfunction

  initial begin
    logic seen_vld;
    logic [30:0] mid;
    rst = 1'b1; start = 1'b0; abort = 1'b0; mode_prbs = 1'b0; marker_en = 1'b0;
    seed = 31'h1234; num_words = '0;
    ns_mac_rdy = 1'b1; fs_mac_rdy = 1'b1; tx_transfer_en = 1'b1;
    #12;
    check("reset data_in", data_in, '0);
    check("reset vld/busy/done/timeout", OW'({data_vld, busy, done, timeout}), '0);
    check("reset word_cnt", OW'(word_cnt), '0);
    rst = 1'b0;
    tick(); tick();

    $display("[TB] counter run");
    num_words = 16'd4;
    pulse_start();
    check("ctr busy", OW'(busy), OW'(1));
    tick();
    expect_word("ctr w0", 80'd0, 1);
    expect_word("ctr w1", 80'd1, 2);
    expect_word("ctr w2", 80'd2, 3);
    expect_word("ctr w3", 80'd3, 4);
    tick();
    check("ctr done/vld/busy", OW'({done, data_vld, busy}), OW'(3'b100));
    check("ctr final cnt", OW'(word_cnt), OW'(4));
    check("ctr data held", data_in, 80'd3);

    $display("[TB] prbs run");
    mode_prbs = 1'b1; seed = 31'h1; num_words = 16'd3;
    pulse_start(); tick();
    expect_word("prbs w0", prbs_word(31'h1), 1);
    check("prbs w0 mid", OW'(data_in[61:31]), OW'(31'h1));
    expect_word("prbs w1", prbs_word(31'h2), 2);
    mid = data_in[61:31];
    check("prbs w1 mid", OW'(mid), OW'(31'h2));
    expect_word("prbs w2", prbs_word(31'h4), 3);
    check("prbs w2 mid", OW'(data_in[61:31]), OW'(31'h4));
    tick();
    check("prbs done", OW'(done), OW'(1));

    $display("[TB] prbs zero seed");
    seed = 31'h0; num_words = 16'd2;
    pulse_start(); tick();
    expect_word("seed0 w0", prbs_word(31'h1), 1);
    expect_word("seed0 w1", prbs_word(31'h2), 2);
    seed = 31'h4000_0000; num_words = 16'd2;
    tick();
    pulse_start(); tick();
    expect_word("tap w0", prbs_word(31'h4000_0000), 1);
    expect_word("tap w1", prbs_word(31'h0000_0001), 2);

    $display("[TB] marker run");
    mode_prbs = 1'b0; marker_en = 1'b1; num_words = 16'd2;
    tick();
    pulse_start(); tick();
    expect_word("mk w0", 80'h8000_0000_0000_0000_0000, 1);
    check("mk w0 bit39", OW'(data_in[39]), '0);
    expect_word("mk w1", 80'h8000_0000_0000_0000_0001, 2);
    tick();
    check("mk done", OW'(done), OW'(1));

    $display("[TB] link pause");
    marker_en = 1'b0; num_words = 16'd5;
    pulse_start(); tick();
    expect_word("lp w0", 80'd0, 1);
    expect_word("lp w1", 80'd1, 2);
    fs_mac_rdy = 1'b0;
    expect_word("lp w2", 80'd2, 3);
    tick();
    check("lp gap1", OW'({data_vld, busy}), OW'(2'b01));
    tick();
    check("lp gap2", OW'(data_vld), '0);
    fs_mac_rdy = 1'b1;
    tick();
    check("lp gap3", OW'(data_vld), '0);
    check("lp cnt held", OW'(word_cnt), OW'(3));
    expect_word("lp w3", 80'd3, 4);
    expect_word("lp w4", 80'd4, 5);
    tick();
    check("lp done", OW'({done, data_vld}), OW'(2'b10));

    $display("[TB] timeout");
    ns_mac_rdy = 1'b0;
    tick(); tick();
    pulse_start();
    seen_vld = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      seen_vld |= data_vld;
    end
    check("to before expiry", OW'({busy, timeout}), OW'(2'b10));
    tick();
    seen_vld |= data_vld;
    check("to expired", OW'({busy, done, timeout}), OW'(3'b001));
    check("to no vld", OW'(seen_vld), '0);

    $display("[TB] abort");
    ns_mac_rdy = 1'b1; num_words = 16'd0;
    tick(); tick();
    pulse_start();
    check("ab timeout cleared", OW'(timeout), '0);
    tick();
    for (int i = 0; i < 10; i++) begin
      if (i == 5) start = 1'b1;
      expect_word("ab word", OW'(i), i + 1);
      start = 1'b0;
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab idle", OW'({busy, done, data_vld}), '0);
    check("ab cnt held", OW'(word_cnt), OW'(10));

    $display("[TB] reset mid-run");
    pulse_start(); tick();
    expect_word("rr w0", 80'd0, 1);
    expect_word("rr w1", 80'd1, 2);
    #2;
    rst = 1'b1;
    #1;
    check("rr outputs", OW'({data_vld, busy, done, timeout}), '0);
    check("rr data", data_in, '0);
    check("rr cnt", OW'(word_cnt), '0);
    tick();
    rst = 1'b0;
    tick();
    check("rr quiet", OW'(data_vld), '0);
    num_words = 16'd2;
    pulse_start(); tick();
    expect_word("rr2 w0", 80'd0, 1);
    expect_word("rr2 w1", 80'd1, 2);
    tick();
    check("rr2 done", OW'(done), OW'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
